bt656_half_scaler: RTL and testbench

BT656_HALF_SCALER -- requirements
Module: bt656_half_scaler

---
 rtl/bt656_half_scaler.sv | 157 +++++++++++++++
 tb/tb_bt656_half_scaler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt656_half_scaler.sv
// Halves a BT.656 decoded 4:2:2 stream: keeps one field and averages pixel pairs,
// packing two scaled pixels per 32-bit FIFO word.
module bt656_half_scaler #(
    parameter int FIELD_SEL = 0,
    parameter int IN_WIDTH  = 720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] yc_data_in,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        field_in,
    input  logic        is_pal_in,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic        frame_start,
    output logic        line_done,
    output logic [8:0]  line_cnt,
    output logic        overflow
);

    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [CW-1:0] PIX_LIMIT = CW'(IN_WIDTH);
    localparam logic KEEP_FIELD = FIELD_SEL[0];

    typedef enum logic [1:0] {WAIT_VS, WAIT_LINE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic            vs_q, de_q;
    logic [CW-1:0]   pix_q, pix_d;
    logic [2:0][7:0] y_q, y_d, c_q, c_d;
    logic            word_valid_q, word_valid_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            frame_start_q, frame_start_d;
    logic            line_done_q, line_done_d;
    logic [8:0]      line_cnt_q, line_cnt_d;
    logic            overflow_q, overflow_d;

    logic       vs_rise, vs_fall, de_rise, de_fall;
    logic [7:0] y_in, c_in;
    logic [8:0] lines_per_field;
    logic       unused_hs;

    assign unused_hs       = hs_in;
    assign vs_rise         = vs_in & ~vs_q;
    assign vs_fall         = ~vs_in & vs_q;
    assign de_rise         = de_in & ~de_q;
    assign de_fall         = ~de_in & de_q;
    assign y_in            = yc_data_in[15:8];
    assign c_in            = yc_data_in[7:0];
    assign lines_per_field = is_pal_in ? 9'd288 : 9'd240;

    // Rounded mean; the 9-bit sum keeps 0xFF+0xFF+1 from wrapping.
    function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    always_comb begin
        state_d       = state_q;
        pix_d         = pix_q;
        y_d           = y_q;
        c_d           = c_q;
        word_valid_d  = 1'b0;
        wr_data_d     = wr_data_q;
        frame_start_d = 1'b0;
        line_done_d   = 1'b0;
        line_cnt_d    = line_cnt_q;
        overflow_d    = overflow_q | (word_valid_q & fifo_full);

        case (state_q)
            WAIT_VS: begin
                if (vs_fall && field_in == KEEP_FIELD) begin
                    state_d       = WAIT_LINE;
                    line_cnt_d    = '0;
                    overflow_d    = 1'b0;
                    frame_start_d = 1'b1;
                end
            end
            WAIT_LINE: begin
                if (vs_rise) begin
                    state_d = WAIT_VS;
                end else if (de_rise) begin
                    state_d = ACTIVE;
                    pix_d   = CW'(1);
                    y_d[0]  = y_in;
                    c_d[0]  = c_in;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = WAIT_VS;
                end else if (de_fall) begin
                    line_done_d = 1'b1;
                    line_cnt_d  = line_cnt_q + 9'd1;
                    state_d     = (line_cnt_d == lines_per_field) ? WAIT_VS : WAIT_LINE;
                end else if (de_in && pix_q < PIX_LIMIT) begin
                    pix_d = pix_q + 1'b1;
                    // p3 is used straight from the input so the word is ready on its edge.
                    case (pix_q[1:0])
                        2'd0: begin y_d[0] = y_in; c_d[0] = c_in; end
                        2'd1: begin y_d[1] = y_in; c_d[1] = c_in; end
                        2'd2: begin y_d[2] = y_in; c_d[2] = c_in; end
                        2'd3: begin
                            word_valid_d = 1'b1;
                            wr_data_d    = {avg(y_q[2], y_in), avg(c_q[1], c_in),
                                            avg(y_q[0], y_q[1]), avg(c_q[0], c_q[2])};
                        end
                    endcase
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_VS;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            pix_q         <= '0;
            y_q           <= '0;
            c_q           <= '0;
            word_valid_q  <= 1'b0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            line_done_q   <= 1'b0;
            line_cnt_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs_in;
            de_q          <= de_in;
            pix_q         <= pix_d;
            y_q           <= y_d;
            c_q           <= c_d;
            word_valid_q  <= word_valid_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            line_done_q   <= line_done_d;
            line_cnt_q    <= line_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    // A full FIFO suppresses the strobe in the very cycle the word is presented.
    assign wr_en       = word_valid_q & ~fifo_full;
    assign wr_data     = wr_data_q;
    assign frame_start = frame_start_q;
    assign line_done   = line_done_q;
    assign line_cnt    = line_cnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bt656_half_scaler.sv
// Bench for bt656_half_scaler: a line-level model predicts every word, pulse and
// counter value per cycle; literal checks pin the model on the directed cases.
module tb_bt656_half_scaler;

    localparam int IN_W = 720;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] yc_data_in = '0;
    logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0, field_in = 1'b0;
    logic        is_pal_in = 1'b1, fifo_full = 1'b0;
    logic        wr_en, frame_start, line_done, overflow;
    logic [31:0] wr_data;
    logic [8:0]  line_cnt;

    bt656_half_scaler #(.FIELD_SEL(0), .IN_WIDTH(IN_W)) dut (
        .clk(clk), .rst_n(rst_n), .yc_data_in(yc_data_in),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .field_in(field_in),
        .is_pal_in(is_pal_in), .fifo_full(fifo_full),
        .wr_en(wr_en), .wr_data(wr_data), .frame_start(frame_start),
        .line_done(line_done), .line_cnt(line_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic [31:0] d; bit drop;} wr_ev_t;

    int          cyc = 0;
    wr_ev_t      wr_q[$];
    int          fs_q[$];
    int          ld_q[$];
    int          exp_lc = 0;
    bit          exp_ovf = 0, ovf_pend = 0;
    bit          m_in_frame = 0;
    int          m_lines = 0;
    int          checks = 0, errors = 0;
    int          words = 0, lds = 0, fss = 0;
    logic [31:0] seen_q[$];
    int          ly[800];
    int          lc[800];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model_word(input int g);
        int b, y01, c02, y23, c13;
        b   = 4 * g;
        y01 = (ly[b] + ly[b+1] + 1) / 2;
        c02 = (lc[b] + lc[b+2] + 1) / 2;
        y23 = (ly[b+2] + ly[b+3] + 1) / 2;
        c13 = (lc[b+1] + lc[b+3] + 1) / 2;
        return {8'(y23), 8'(c13), 8'(y01), 8'(c02)};
    endfunction

    function automatic bit in_drop(input int g, input int lo, input int n);
        return (g >= lo) && (g < lo + n);
    endfunction

    always @(negedge clk) begin : compare
        wr_ev_t ev;
        logic   exp_wr, exp_fs, exp_ld;
        if (ovf_pend) begin
            exp_ovf  = 1'b1;
            ovf_pend = 1'b0;
        end
        exp_fs = (fs_q.size() > 0) && (fs_q[0] == cyc);
        if (exp_fs) begin
            void'(fs_q.pop_front());
            exp_lc  = 0;
            exp_ovf = 1'b0;
        end
        exp_ld = (ld_q.size() > 0) && (ld_q[0] == cyc);
        if (exp_ld) begin
            void'(ld_q.pop_front());
            exp_lc++;
        end
        exp_wr = 1'b0;
        ev     = '{cyc: 0, d: '0, drop: 1'b0};
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            ev = wr_q.pop_front();
            if (ev.drop) ovf_pend = 1'b1;
            else exp_wr = 1'b1;
        end
        chk("wr_en", {31'd0, wr_en}, {31'd0, exp_wr});
        if (exp_wr && wr_en) chk("wr_data", wr_data, ev.d);
        chk("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
        chk("line_done", {31'd0, line_done}, {31'd0, exp_ld});
        chk("line_cnt", {23'd0, line_cnt}, 32'(exp_lc));
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        if (wr_en) begin
            words++;
            seen_q.push_back(wr_data);
        end
        if (line_done) lds++;
        if (frame_start) fss++;
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
        chk({tag, "_line_done"}, {31'd0, line_done}, 32'd0);
        chk({tag, "_line_cnt"}, {23'd0, line_cnt}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        de_in     = 1'b0;
        fifo_full = 1'b0;
        wr_q.delete();
        fs_q.delete();
        ld_q.delete();
        exp_lc     = 0;
        exp_ovf    = 1'b0;
        ovf_pend   = 1'b0;
        m_in_frame = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        de_in     = 1'b0;
        hs_in     = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic start_frame(input bit field);
        field_in = field;
        repeat (3) begin idle(); vs_in = 1'b1; end
        m_in_frame = 1'b0;
        idle();
        vs_in = 1'b0;
        if (field == 1'b0) begin
            fs_q.push_back(cyc + 1);
            m_in_frame = 1'b1;
            m_lines    = 0;
        end
        repeat (2) idle();
    endtask

    // Drives n de pixels from ly/lc, then one de-low cycle; predicts all outputs.
    task automatic drive_line(input int n, input int drop_lo, input int ndrop,
                              input int abort_at, input int rst_at);
        bit     act;
        wr_ev_t ev;
        act   = m_in_frame;
        words = 0;
        seen_q.delete();
        repeat (2) idle();
        for (int i = 0; i <= n; i++) begin
            @(posedge clk);
            #2;
            fifo_full = (i > 0) && ((i - 1) % 4 == 3) && in_drop((i - 1) / 4, drop_lo, ndrop);
            if (i == rst_at) begin
                do_reset();
                $display("line n=%0d reset at pixel %0d words=%0d", n, i, words);
                return;
            end
            if (i < n) begin
                de_in      = 1'b1;
                yc_data_in = {8'(ly[i]), 8'(lc[i])};
                if (i == abort_at) begin
                    vs_in      = 1'b1;
                    m_in_frame = 1'b0;
                    idle();
                    break;
                end
                if (act && i < IN_W && i % 4 == 3) begin
                    ev.cyc  = cyc + 1;
                    ev.d    = model_word(i / 4);
                    ev.drop = in_drop(i / 4, drop_lo, ndrop);
                    wr_q.push_back(ev);
                end
            end else begin
                de_in = 1'b0;
                hs_in = 1'b1;
                if (act) begin
                    ld_q.push_back(cyc + 1);
                    m_lines++;
                    if (m_lines == (is_pal_in ? 288 : 240)) m_in_frame = 1'b0;
                end
            end
        end
        repeat (2) idle();
        if (n > 8) $display("line n=%0d words=%0d line_cnt=%0d overflow=%0b", n, words, line_cnt, overflow);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 800; i++) begin
            ly[i] = i % 256;
            lc[i] = (i % 2 == 0) ? 'h80 : 'h40;
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lds0;
        #2;
        do_reset();

        // Wrong field is ignored entirely.
        fill_ramp();
        start_frame(1'b1);
        drive_line(720, -1, 0, -1, -1);
        chk("field1_words", 32'(words), 32'd0);
        chk("field1_frame_start", 32'(fss), 32'd0);

        start_frame(1'b0);
        chk("frame_start_count", 32'(fss), 32'd1);
        drive_line(720, -1, 0, -1, -1);
        chk("ramp_words", 32'(words), 32'd180);
        chk("ramp_first_word", seen_q.size() > 0 ? seen_q[0] : 32'hx, 32'h0340_0180);

        for (int i = 0; i < 800; i++) begin ly[i] = 0; lc[i] = 0; end
        ly[0] = 'hFF; ly[1] = 'hFE; lc[0] = 'hFF; lc[2] = 'hFF;
        ly[4] = 1;    ly[5] = 0;
        drive_line(8, -1, 0, -1, -1);
        chk("round_words", 32'(words), 32'd2);
        chk("round_out0_max", {16'd0, seen_q.size() > 0 ? seen_q[0][15:0] : 16'hx}, 32'h0000_FFFF);
        chk("round_y_one", {24'd0, seen_q.size() > 1 ? seen_q[1][15:8] : 8'hx}, 32'h0000_0001);

        fill_ramp();
        drive_line(720, 10, 3, -1, -1);
        chk("backpressure_words", 32'(words), 32'd177);
        chk("backpressure_overflow", {31'd0, overflow}, 32'd1);

        drive_line(722, -1, 0, -1, -1);
        chk("long_line_words", 32'(words), 32'd180);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        lds0 = lds;
        drive_line(720, -1, 0, 100, -1);
        chk("abort_words", 32'(words), 32'd25);
        chk("abort_no_line_done", 32'(lds - lds0), 32'd0);
        chk("abort_line_cnt", {23'd0, line_cnt}, 32'd4);

        start_frame(1'b0);
        chk("newframe_overflow", {31'd0, overflow}, 32'd0);
        chk("newframe_line_cnt", {23'd0, line_cnt}, 32'd0);

        // Full PAL field of short lines, then one more line that must be ignored.
        lds0 = lds;
        for (int l = 0; l < 288; l++) drive_line(4, -1, 0, -1, -1);
        chk("pal_line_done_count", 32'(lds - lds0), 32'd288);
        chk("pal_final_line_cnt", {23'd0, line_cnt}, 32'd288);
        drive_line(8, -1, 0, -1, -1);
        chk("pal_after_field_words", 32'(words), 32'd0);

        is_pal_in = 1'b0;
        start_frame(1'b0);
        lds0 = lds;
        for (int l = 0; l < 240; l++) drive_line(4, -1, 0, -1, -1);
        chk("ntsc_line_done_count", 32'(lds - lds0), 32'd240);
        drive_line(8, -1, 0, -1, -1);
        chk("ntsc_after_field_words", 32'(words), 32'd0);
        is_pal_in = 1'b1;

        // Reset in the middle of line 3, then nothing until a kept-field vs fall.
        start_frame(1'b0);
        drive_line(8, -1, 0, -1, -1);
        drive_line(8, -1, 0, -1, -1);
        drive_line(720, -1, 0, -1, 50);
        drive_line(720, -1, 0, -1, -1);
        chk("post_reset_words", 32'(words), 32'd0);
        start_frame(1'b1);
        drive_line(8, -1, 0, -1, -1);
        chk("post_reset_field1_words", 32'(words), 32'd0);
        start_frame(1'b0);
        drive_line(8, -1, 0, -1, -1);
        chk("post_reset_resume_words", 32'(words), 32'd2);

        repeat (4) idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
